// File: rtl/legv8_pkg.sv
// Shared encodings for the LEGv8 multi-cycle control path: opcodes, masks,
// FSM states, instruction classes and the datapath select encodings.
package legv8_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_e;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_R,
        CLS_I,
        CLS_LDUR,
        CLS_STUR,
        CLS_B,
        CLS_BL,
        CLS_CB,
        CLS_BCOND,
        CLS_BR
    } inst_class_e;

    localparam logic [2:0] BR_SEQ   = 3'b000;
    localparam logic [2:0] BR_B     = 3'b001;
    localparam logic [2:0] BR_CBZ   = 3'b010;
    localparam logic [2:0] BR_CBNZ  = 3'b011;
    localparam logic [2:0] BR_BCOND = 3'b100;
    localparam logic [2:0] BR_BR    = 3'b101;
    localparam logic [2:0] BR_BL    = 3'b110;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_PASS  = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC4 = 2'b10;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_IMEM_TO  = 2'b10;
    localparam logic [1:0] ERR_DMEM_TO  = 2'b11;

    // R-format, LDUR/STUR and BR are full 11-bit matches
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ANDS = 11'b11101010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_BR   = 11'b11010110000;

    localparam logic [10:0] MASK_I   = 11'b11111111110;
    localparam logic [10:0] OP_ADDI  = 11'b10010001000;
    localparam logic [10:0] OP_ADDIS = 11'b10110001000;
    localparam logic [10:0] OP_SUBI  = 11'b11010001000;
    localparam logic [10:0] OP_SUBIS = 11'b11110001000;
    localparam logic [10:0] OP_ANDI  = 11'b10010010000;
    localparam logic [10:0] OP_ANDIS = 11'b11110010000;
    localparam logic [10:0] OP_ORRI  = 11'b10110010000;
    localparam logic [10:0] OP_EORI  = 11'b11010010000;

    localparam logic [10:0] MASK_CB  = 11'b11111111000;
    localparam logic [10:0] OP_CBZ   = 11'b10110100000;
    localparam logic [10:0] OP_CBNZ  = 11'b10110101000;
    localparam logic [10:0] OP_BCOND = 11'b01010100000;

    localparam logic [10:0] MASK_B = 11'b11111100000;
    localparam logic [10:0] OP_B   = 11'b00010100000;
    localparam logic [10:0] OP_BL  = 11'b10010100000;

    typedef struct packed {
        inst_class_e cls;
        logic        set_flags;
        logic        reg2loc;
        logic        alu_src;
        logic [1:0]  alu_op;
        logic        wreg_loc;
        logic [1:0]  mem_to_reg;
        logic [2:0]  branch_op;
    } ctrl_fields_t;

    function automatic logic op_match(logic [10:0] op, logic [10:0] mask, logic [10:0] val);
        return (op & mask) == val;
    endfunction

endpackage

// File: rtl/legv8_mc_decode.sv
// Combinational opcode classifier: instruction class, static datapath
// selects and an illegal flag for anything not in the supported subset.
module legv8_mc_decode
    import legv8_pkg::*;
(
    input  logic [10:0] opcode,
    output logic [3:0]  cls,
    output logic        illegal,
    output logic        set_flags,
    output logic        reg2loc,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic        wreg_loc,
    output logic [1:0]  mem_to_reg,
    output logic [2:0]  branch_op
);

    logic [10:0] op_i;
    assign op_i = opcode & MASK_I;

    always_comb begin
        cls        = CLS_NONE;
        illegal    = 1'b0;
        set_flags  = 1'b0;
        reg2loc    = 1'b0;
        alu_src    = 1'b0;
        alu_op     = ALU_ADD;
        wreg_loc   = 1'b0;
        mem_to_reg = M2R_ALU;
        branch_op  = BR_SEQ;
        if (opcode inside {OP_ADD, OP_ADDS, OP_SUB, OP_SUBS, OP_AND, OP_ANDS,
                           OP_ORR, OP_EOR, OP_LSL, OP_LSR}) begin
            cls       = CLS_R;
            alu_op    = ALU_FUNCT;
            set_flags = opcode inside {OP_ADDS, OP_SUBS, OP_ANDS};
        end else if (op_i inside {OP_ADDI, OP_ADDIS, OP_SUBI, OP_SUBIS,
                                  OP_ANDI, OP_ANDIS, OP_ORRI, OP_EORI}) begin
            cls       = CLS_I;
            alu_src   = 1'b1;
            alu_op    = ALU_FUNCT;
            set_flags = op_i inside {OP_ADDIS, OP_SUBIS, OP_ANDIS};
        end else if (opcode == OP_LDUR) begin
            cls        = CLS_LDUR;
            alu_src    = 1'b1;
            mem_to_reg = M2R_MDR;
        end else if (opcode == OP_STUR) begin
            cls     = CLS_STUR;
            alu_src = 1'b1;
            reg2loc = 1'b1;
        end else if (opcode == OP_BR) begin
            cls       = CLS_BR;
            branch_op = BR_BR;
        end else if (op_match(opcode, MASK_CB, OP_CBZ) || op_match(opcode, MASK_CB, OP_CBNZ)) begin
            cls       = CLS_CB;
            reg2loc   = 1'b1;
            alu_op    = ALU_PASS;
            branch_op = opcode[3] ? BR_CBNZ : BR_CBZ;
        end else if (op_match(opcode, MASK_CB, OP_BCOND)) begin
            cls       = CLS_BCOND;
            branch_op = BR_BCOND;
        end else if (op_match(opcode, MASK_B, OP_B)) begin
            cls       = CLS_B;
            branch_op = BR_B;
        end else if (op_match(opcode, MASK_B, OP_BL)) begin
            cls        = CLS_BL;
            wreg_loc   = 1'b1;
            mem_to_reg = M2R_PC4;
            branch_op  = BR_BL;
        end else begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/legv8_mc_ctrl.sv
// Multi-cycle LEGv8 control FSM: FETCH/DECODE/EXEC/MEM/WB with imem/dmem handshakes.
// Define LEGV8_MC_TIMEOUT_EN to enable the memory-wait watchdog (err_code 10/11).
module legv8_mc_ctrl
    import legv8_pkg::*;
#(
    parameter int WAIT_W   = 8,
    parameter int WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] opcode,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        IRWrite,
    output logic        MDRWrite,
    output logic        PCWrite,
    output logic        Reg2Loc,
    output logic        RegWrite,
    output logic        WRegLoc,
    output logic        ALUSrc,
    output logic [1:0]  ALUOp,
    output logic        SregUp,
    output logic [2:0]  BranchOp,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [1:0]  MemtoReg,
    output logic [1:0]  err_code
);

    if (WAIT_MAX < 1 || WAIT_MAX >= (1 << WAIT_W)) begin : g_bad_wait_max
        $error("WAIT_MAX must lie in [1, 2**WAIT_W)");
    end

    state_e       state_q, state_d;
    ctrl_fields_t fld_q, fld_d, dec_fld;
    logic [1:0]   err_q, err_d;
    logic         dec_illegal;
    logic [3:0]   dec_cls;
    logic         wait_expired;

    legv8_mc_decode u_decode (
        .opcode     (opcode),
        .cls        (dec_cls),
        .illegal    (dec_illegal),
        .set_flags  (dec_fld.set_flags),
        .reg2loc    (dec_fld.reg2loc),
        .alu_src    (dec_fld.alu_src),
        .alu_op     (dec_fld.alu_op),
        .wreg_loc   (dec_fld.wreg_loc),
        .mem_to_reg (dec_fld.mem_to_reg),
        .branch_op  (dec_fld.branch_op)
    );
    assign dec_fld.cls = inst_class_e'(dec_cls);

`ifdef LEGV8_MC_TIMEOUT_EN
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    // Counts unacknowledged request cycles; any non-waiting cycle clears it,
    // which covers the clear-on-entry to FETCH and MEM.
    always_comb begin
        wait_cnt_d = '0;
        if ((state_q == ST_FETCH && !imem_ack) || (state_q == ST_MEM && !dmem_ack))
            wait_cnt_d = wait_cnt_q + 1'b1;
    end

    assign wait_expired = (wait_cnt_q == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (rst) wait_cnt_q <= '0;
        else     wait_cnt_q <= wait_cnt_d;
    end
`else
    assign wait_expired = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        fld_d    = fld_q;
        err_d    = err_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        IRWrite  = 1'b0;
        MDRWrite = 1'b0;
        PCWrite  = 1'b0;
        RegWrite = 1'b0;
        SregUp   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        case (state_q)
            ST_RESET: state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    IRWrite = 1'b1;
                    state_d = ST_DECODE;
                end else if (wait_expired) begin
                    state_d = ST_HALT;
                    err_d   = ERR_IMEM_TO;
                end
            end
            ST_DECODE: begin
                fld_d = dec_fld;
                if (dec_illegal) begin
                    state_d = ST_HALT;
                    err_d   = ERR_ILLEGAL;
                end else begin
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (fld_q.cls)
                    CLS_R, CLS_I: begin
                        SregUp  = fld_q.set_flags;
                        state_d = ST_WB;
                    end
                    CLS_LDUR, CLS_STUR: state_d = ST_MEM;
                    CLS_BL: begin
                        PCWrite  = 1'b1;
                        RegWrite = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    CLS_B, CLS_CB, CLS_BCOND, CLS_BR: begin
                        PCWrite = 1'b1;
                        state_d = ST_FETCH;
                    end
                    default: state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                MemRead  = (fld_q.cls == CLS_LDUR);
                if (dmem_ack) begin
                    if (fld_q.cls == CLS_LDUR) begin
                        MDRWrite = 1'b1;
                        state_d  = ST_WB;
                    end else begin
                        MemWrite = 1'b1;
                        PCWrite  = 1'b1;
                        state_d  = ST_FETCH;
                    end
                end else if (wait_expired) begin
                    state_d = ST_HALT;
                    err_d   = ERR_DMEM_TO;
                end
            end
            ST_WB: begin
                RegWrite = 1'b1;
                PCWrite  = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_RESET;
        endcase
        // A halted core shows neutral selects, whatever caused the halt
        if (state_d == ST_HALT) fld_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            fld_q   <= '0;
            err_q   <= ERR_OK;
        end else begin
            state_q <= state_d;
            fld_q   <= fld_d;
            err_q   <= err_d;
        end
    end

    assign Reg2Loc  = fld_q.reg2loc;
    assign ALUSrc   = fld_q.alu_src;
    assign ALUOp    = fld_q.alu_op;
    assign WRegLoc  = fld_q.wreg_loc;
    assign MemtoReg = fld_q.mem_to_reg;
    assign BranchOp = fld_q.branch_op;
    assign err_code = err_q;

endmodule

// File: tb/tb_legv8_mc_ctrl.sv
// Self-checking bench for legv8_mc_ctrl: directed vector table, hand-built
// corner sequences and randomized instructions against a per-instruction schedule model.
module tb_legv8_mc_ctrl;

`ifdef LEGV8_MC_TIMEOUT_EN
    localparam int TB_WAIT_MAX = 4;
`else
    localparam int TB_WAIT_MAX = 255;
`endif

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_BL = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] opcode = '0;
    logic        imem_ack = 1'b0, dmem_ack = 1'b0;
    logic        imem_req, dmem_req, IRWrite, MDRWrite, PCWrite, Reg2Loc, RegWrite;
    logic        WRegLoc, ALUSrc, SregUp, MemRead, MemWrite;
    logic [1:0]  ALUOp, MemtoReg, err_code;
    logic [2:0]  BranchOp;

    int checks = 0;
    int errors = 0;
    logic [9:0] last_f;
    bit         seen_sreg;

    always #5 clk = ~clk;

    legv8_mc_ctrl #(.WAIT_W(8), .WAIT_MAX(TB_WAIT_MAX)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .imem_req(imem_req), .dmem_req(dmem_req), .IRWrite(IRWrite), .MDRWrite(MDRWrite),
        .PCWrite(PCWrite), .Reg2Loc(Reg2Loc), .RegWrite(RegWrite), .WRegLoc(WRegLoc),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .SregUp(SregUp), .BranchOp(BranchOp),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .err_code(err_code)
    );

    typedef struct {
        bit         legal;
        int         kind;
        bit         sreg;
        logic [9:0] f;   // {Reg2Loc, ALUSrc, ALUOp, WRegLoc, MemtoReg, BranchOp}
    } dec_t;

    typedef struct {
        logic [10:0] op;
        int          iw;
        int          dw;
        int          cyc;
        logic [9:0]  f;
        bit          sreg;
    } vec_t;

    // Reference classification written straight from the instruction tables
    function automatic dec_t tb_dec(logic [10:0] op);
        dec_t d;
        d.legal = 1'b1; d.kind = K_R; d.sreg = 1'b0; d.f = '0;
        casez (op)
            11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000,
            11'b11001010000, 11'b11010011011, 11'b11010011010:
                d.f = 10'b0_0_10_0_00_000;
            11'b10101011000, 11'b11101011000, 11'b11101010000: begin
                d.f = 10'b0_0_10_0_00_000; d.sreg = 1'b1;
            end
            11'b1001000100?, 11'b1101000100?, 11'b1001001000?, 11'b1011001000?, 11'b1101001000?: begin
                d.kind = K_I; d.f = 10'b0_1_10_0_00_000;
            end
            11'b1011000100?, 11'b1111000100?, 11'b1111001000?: begin
                d.kind = K_I; d.f = 10'b0_1_10_0_00_000; d.sreg = 1'b1;
            end
            11'b11111000010: begin d.kind = K_LD; d.f = 10'b0_1_00_0_01_000; end
            11'b11111000000: begin d.kind = K_ST; d.f = 10'b1_1_00_0_00_000; end
            11'b000101?????: begin d.kind = K_BR; d.f = 10'b0_0_00_0_00_001; end
            11'b100101?????: begin d.kind = K_BL; d.f = 10'b0_0_00_1_10_110; end
            11'b10110100???: begin d.kind = K_BR; d.f = 10'b1_0_01_0_00_010; end
            11'b10110101???: begin d.kind = K_BR; d.f = 10'b1_0_01_0_00_011; end
            11'b01010100???: begin d.kind = K_BR; d.f = 10'b0_0_00_0_00_100; end
            11'b11010110000: begin d.kind = K_BR; d.f = 10'b0_0_00_0_00_101; end
            default:         d.legal = 1'b0;
        endcase
        return d;
    endfunction

    // Strobe vector: {imem_req, dmem_req, IRWrite, MDRWrite, PCWrite, RegWrite, SregUp, MemRead, MemWrite, err_code}
    function automatic logic [10:0] sv(bit ir, bit dr, bit irw, bit mdrw, bit pcw, bit rw,
                                       bit sr, bit mr, bit mw, logic [1:0] err);
        return {ir, dr, irw, mdrw, pcw, rw, sr, mr, mw, err};
    endfunction

    function automatic bit nz();
        return bit'($urandom_range(0, 1));
    endfunction

    // Called at posedge+1: drive acks, check outputs at negedge, advance one cycle
    task automatic step(input bit ia, input bit da, input string nm,
                        input logic [10:0] es, input bit cf, input logic [9:0] ef);
        logic [10:0] as;
        logic [9:0]  af;
        imem_ack = ia;
        dmem_ack = da;
        @(negedge clk);
        as = {imem_req, dmem_req, IRWrite, MDRWrite, PCWrite, RegWrite, SregUp, MemRead, MemWrite, err_code};
        af = {Reg2Loc, ALUSrc, ALUOp, WRegLoc, MemtoReg, BranchOp};
        last_f = af;
        if (SregUp) seen_sreg = 1'b1;
        checks++;
        if (as !== es) begin
            errors++;
            $display("FAIL %s strobes got %b want %b", nm, as, es);
        end
        if (cf) begin
            checks++;
            if (af !== ef) begin
                errors++;
                $display("FAIL %s fields got %b want %b", nm, af, ef);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, "reset_state", '0, 1'b1, '0);
    endtask

    // Expected per-cycle trace of one instruction, starting in its first FETCH cycle
    task automatic run_instr(input logic [10:0] op, input int iw, input int dw,
                             input string tag, output int cyc);
        dec_t d;
        bit ld;
        d = tb_dec(op);
        ld = (d.kind == K_LD);
        cyc = 0;
        seen_sreg = 1'b0;
        opcode = op;
        for (int k = 0; k < iw; k++) begin
            step(1'b0, nz(), {tag, "/fetch_wait"}, sv(1,0,0,0,0,0,0,0,0,2'b00), 1'b0, '0);
            cyc++;
        end
        step(1'b1, nz(), {tag, "/fetch_ack"}, sv(1,0,1,0,0,0,0,0,0,2'b00), 1'b0, '0);
        cyc++;
        step(nz(), nz(), {tag, "/decode"}, '0, 1'b0, '0);
        cyc++;
        if (!d.legal) begin
            for (int k = 0; k < 3; k++)
                step(nz(), nz(), {tag, "/halt"}, sv(0,0,0,0,0,0,0,0,0,2'b01), 1'b0, '0);
            return;
        end
        case (d.kind)
            K_R, K_I: begin
                step(nz(), nz(), {tag, "/exec"}, sv(0,0,0,0,0,0,d.sreg,0,0,2'b00), 1'b1, d.f);
                step(nz(), nz(), {tag, "/wb"}, sv(0,0,0,0,1,1,0,0,0,2'b00), 1'b1, d.f);
                cyc += 2;
            end
            K_BR: begin
                step(nz(), nz(), {tag, "/exec_br"}, sv(0,0,0,0,1,0,0,0,0,2'b00), 1'b1, d.f);
                cyc++;
            end
            K_BL: begin
                step(nz(), nz(), {tag, "/exec_bl"}, sv(0,0,0,0,1,1,0,0,0,2'b00), 1'b1, d.f);
                cyc++;
            end
            default: begin
                step(nz(), nz(), {tag, "/exec_mem"}, '0, 1'b1, d.f);
                cyc++;
                for (int k = 0; k < dw; k++) begin
                    step(nz(), 1'b0, {tag, "/mem_wait"}, sv(0,1,0,0,0,0,0,ld,0,2'b00), 1'b1, d.f);
                    cyc++;
                end
                step(nz(), 1'b1, {tag, "/mem_ack"}, sv(0,1,0,ld,!ld,0,0,ld,!ld,2'b00), 1'b1, d.f);
                cyc++;
                if (ld) begin
                    step(nz(), nz(), {tag, "/wb_ld"}, sv(0,0,0,0,1,1,0,0,0,2'b00), 1'b1, d.f);
                    cyc++;
                end
            end
        endcase
    endtask

    task automatic cmp_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    vec_t        tbl[12];
    logic [10:0] bases[14];
    logic [10:0] dcm[14];

    initial begin
        int c;
        logic [10:0] op;
        dec_t d;

        tbl[0]  = '{11'b10001011000, 0, 0, 4, 10'b0_0_10_0_00_000, 1'b0}; // ADD
        tbl[1]  = '{11'b11111000010, 0, 3, 8, 10'b0_1_00_0_01_000, 1'b0}; // LDUR, 3 waits
        tbl[2]  = '{11'b10010100101, 0, 0, 3, 10'b0_0_00_1_10_110, 1'b0}; // BL
        tbl[3]  = '{11'b11111000000, 0, 0, 4, 10'b1_1_00_0_00_000, 1'b0}; // STUR
        tbl[4]  = '{11'b10110100011, 1, 0, 4, 10'b1_0_01_0_00_010, 1'b0}; // CBZ
        tbl[5]  = '{11'b10101011000, 2, 0, 6, 10'b0_0_10_0_00_000, 1'b1}; // ADDS
        tbl[6]  = '{11'b11110001001, 0, 0, 4, 10'b0_1_10_0_00_000, 1'b1}; // SUBIS
        tbl[7]  = '{11'b01010100000, 0, 0, 3, 10'b0_0_00_0_00_100, 1'b0}; // B.cond
        tbl[8]  = '{11'b11010110000, 0, 0, 3, 10'b0_0_00_0_00_101, 1'b0}; // BR
        tbl[9]  = '{11'b10110101111, 0, 0, 3, 10'b1_0_01_0_00_011, 1'b0}; // CBNZ
        tbl[10] = '{11'b00010111111, 0, 0, 3, 10'b0_0_00_0_00_001, 1'b0}; // B
        tbl[11] = '{11'b11111000010, 2, 1, 8, 10'b0_1_00_0_01_000, 1'b0}; // LDUR, mixed waits

        bases = '{11'b10001011000, 11'b11101011000, 11'b11001010000, 11'b11010011011,
                  11'b10010001000, 11'b11110010000, 11'b11111000010, 11'b11111000000,
                  11'b00010100000, 11'b10010100000, 11'b10110100000, 11'b10110101000,
                  11'b01010100000, 11'b11010110000};
        dcm   = '{11'h000, 11'h000, 11'h000, 11'h000, 11'h001, 11'h001, 11'h000, 11'h000,
                  11'h01f, 11'h01f, 11'h007, 11'h007, 11'h007, 11'h000};

        do_reset();

        // Directed vector table, back to back
        foreach (tbl[i]) begin
            run_instr(tbl[i].op, tbl[i].iw, tbl[i].dw, $sformatf("vec%0d", i), c);
            cmp_int($sformatf("vec%0d/cycles", i), c, tbl[i].cyc);
            checks++;
            if (last_f !== tbl[i].f) begin
                errors++;
                $display("FAIL vec%0d/retire_fields got %b want %b", i, last_f, tbl[i].f);
            end
            cmp_int($sformatf("vec%0d/sregup", i), int'(seen_sreg), int'(tbl[i].sreg));
        end

        // Illegal opcode halts sticky, then reset restarts fetch
        run_instr(11'b00000000000, 0, 0, "illegal", c);
        for (int k = 0; k < 5; k++)
            step(1'b1, 1'b1, "illegal_sticky", sv(0,0,0,0,0,0,0,0,0,2'b01), 1'b0, '0);
        do_reset();
        run_instr(11'b10001011000, 0, 0, "after_illegal", c);
        cmp_int("after_illegal/cycles", c, 4);

        // rst while STUR waits in MEM; late ack must not complete the store
        do_reset();
        opcode = 11'b11111000000;
        step(1'b1, 1'b0, "stur_rst/fetch", sv(1,0,1,0,0,0,0,0,0,2'b00), 1'b0, '0);
        step(1'b0, 1'b0, "stur_rst/decode", '0, 1'b0, '0);
        step(1'b0, 1'b0, "stur_rst/exec", '0, 1'b0, '0);
        step(1'b0, 1'b0, "stur_rst/mem_wait", sv(0,1,0,0,0,0,0,0,0,2'b00), 1'b0, '0);
        rst = 1'b1;
        step(1'b0, 1'b0, "stur_rst/rst_cycle", sv(0,1,0,0,0,0,0,0,0,2'b00), 1'b0, '0);
        rst = 1'b0;
        step(1'b0, 1'b1, "stur_rst/late_ack", '0, 1'b0, '0);
        run_instr(11'b11111000000, 0, 0, "stur_rst/restart", c);
        cmp_int("stur_rst/restart_cycles", c, 4);

`ifdef LEGV8_MC_TIMEOUT_EN
        do_reset();
        for (int k = 0; k < TB_WAIT_MAX; k++)
            step(1'b0, 1'b0, "imem_to/wait", sv(1,0,0,0,0,0,0,0,0,2'b00), 1'b0, '0);
        step(1'b1, 1'b0, "imem_to/halt", sv(0,0,0,0,0,0,0,0,0,2'b10), 1'b0, '0);
        step(1'b1, 1'b1, "imem_to/sticky", sv(0,0,0,0,0,0,0,0,0,2'b10), 1'b0, '0);
        do_reset();
        opcode = 11'b11111000010;
        step(1'b1, 1'b0, "dmem_to/fetch", sv(1,0,1,0,0,0,0,0,0,2'b00), 1'b0, '0);
        step(1'b0, 1'b0, "dmem_to/decode", '0, 1'b0, '0);
        step(1'b0, 1'b0, "dmem_to/exec", '0, 1'b0, '0);
        for (int k = 0; k < TB_WAIT_MAX; k++)
            step(1'b0, 1'b0, "dmem_to/wait", sv(0,1,0,0,0,0,0,1,0,2'b00), 1'b0, '0);
        step(1'b0, 1'b1, "dmem_to/halt", sv(0,0,0,0,0,0,0,0,0,2'b11), 1'b0, '0);
`else
        do_reset();
        run_instr(11'b10001011000, 120, 0, "no_timeout", c);
        cmp_int("no_timeout/cycles", c, 124);
`endif

        // Randomized instructions and wait patterns against the schedule model
        do_reset();
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 5) == 0) begin
                op = 11'($urandom);
            end else begin
                int j;
                j  = $urandom_range(0, 13);
                op = bases[j] | (11'($urandom) & dcm[j]);
            end
            d = tb_dec(op);
            run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd%0d", n), c);
            if (!d.legal) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
